// File: rtl/dmg_irq_ctrl.sv
// DMG interrupt controller: IF/IE registers on the core bus, edge-detected
// peripheral requests, pending-and-enabled trigger vector and HALT/STOP wake.

module dmg_irq_bit (
  input  logic CLK,
  input  logic RESET_N,
  input  logic arm_i,
  input  logic src_i,
  input  logic ack_i,
  input  logic wr_i,
  input  logic wd_i,
  output logic flag_o
);
  logic src_prev_q, ack_prev_q, flag_q, flag_d, set, clr;

  assign set    = arm_i & src_i & ~src_prev_q;
  assign clr    = ack_i & ~ack_prev_q;
  // Source set beats ack clear, which beats the CPU write.
  assign flag_d = ((wr_i ? wd_i : flag_q) & ~clr) | set;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      src_prev_q <= 1'b0;
      ack_prev_q <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      src_prev_q <= src_i;
      ack_prev_q <= ack_i;
      flag_q     <= flag_d;
    end
  end

  assign flag_o = flag_q;
endmodule

module dmg_irq_ctrl #(
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF,
  parameter int          NUM_SRC = 5
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] A,
  input  logic [7:0]  D_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  input  logic        RD,
  input  logic        WR,
  input  logic [7:0]  IRQ_SRC,
  output logic [7:0]  CPU_IRQ_TRIG,
  input  logic [7:0]  CPU_IRQ_ACK,
  output logic        WAKE
);
  localparam logic [7:0] IMPL = 8'((1 << NUM_SRC) - 1);

  logic       wr_prev_q, arm_q;
  logic [7:0] ie_q, ie_d, if_flags;
  logic       hit_if, hit_ie, wr_edge;
  logic       unused_hi;

  assign hit_if  = (A == IF_ADDR);
  assign hit_ie  = (A == IE_ADDR);
  assign wr_edge = WR & ~wr_prev_q;
  assign ie_d    = (wr_edge & hit_ie) ? D_IN : ie_q;

  // Sources are ignored for the first cycle out of reset, so that cycle only
  // primes the edge history and a line already high does not raise a request.
  generate
    for (genvar i = 0; i < 8; i++) begin : g_bit
      if (i < NUM_SRC) begin : g_impl
        dmg_irq_bit u_bit (
          .CLK    (CLK),
          .RESET_N(RESET_N),
          .arm_i  (arm_q),
          .src_i  (IRQ_SRC[i]),
          .ack_i  (CPU_IRQ_ACK[i]),
          .wr_i   (wr_edge & hit_if),
          .wd_i   (D_IN[i]),
          .flag_o (if_flags[i])
        );
      end else begin : g_tie
        assign if_flags[i] = 1'b0;
      end
    end
  endgenerate

  assign unused_hi = ^{IRQ_SRC, CPU_IRQ_ACK};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_prev_q <= 1'b0;
      arm_q     <= 1'b0;
      ie_q      <= 8'h00;
    end else begin
      wr_prev_q <= WR;
      arm_q     <= 1'b1;
      ie_q      <= ie_d;
    end
  end

  assign CPU_IRQ_TRIG = if_flags & ie_q;
  assign WAKE         = |CPU_IRQ_TRIG;
  assign D_OE         = RESET_N & RD & (hit_if | hit_ie);

  always_comb begin
    D_OUT = 8'h00;
    if (D_OE) D_OUT = hit_if ? (if_flags | ~IMPL) : ie_q;
  end
endmodule

// File: tb/tb_dmg_irq_ctrl.sv
// Bench for dmg_irq_ctrl: vector table, directed corner sequences and a
// randomized run against a cycle-level reference model.
module tb_dmg_irq_ctrl;
  localparam logic [15:0] IFA = 16'hFF0F;
  localparam logic [15:0] IEA = 16'hFFFF;
  localparam logic [15:0] OTH = 16'hFF10;

  logic        CLK = 1'b0;
  logic        RESET_N, D_OE, RD, WR, WAKE;
  logic [15:0] A;
  logic [7:0]  D_IN, D_OUT, IRQ_SRC, CPU_IRQ_TRIG, CPU_IRQ_ACK;

  int n_chk = 0;
  int n_err = 0;

  dmg_irq_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .A(A), .D_IN(D_IN), .D_OUT(D_OUT),
    .D_OE(D_OE), .RD(RD), .WR(WR), .IRQ_SRC(IRQ_SRC),
    .CPU_IRQ_TRIG(CPU_IRQ_TRIG), .CPU_IRQ_ACK(CPU_IRQ_ACK), .WAKE(WAKE)
  );

  always #5 CLK = ~CLK;

  // Reference model state: what the spec says the registers hold.
  logic [7:0] m_if, m_ie, m_sp, m_ap;
  logic       m_wp, m_arm;

  task automatic m_clear();
    m_if = 8'h00; m_ie = 8'h00; m_sp = 8'h00; m_ap = 8'h00;
    m_wp = 1'b0;  m_arm = 1'b0;
  endtask

  task automatic m_step();
    logic [7:0] set, clr, base;
    logic       wr;
    if (!RESET_N) begin
      m_clear();
    end else begin
      set  = m_arm ? (IRQ_SRC & ~m_sp) : 8'h00;
      clr  = CPU_IRQ_ACK & ~m_ap;
      wr   = WR && !m_wp;
      base = (wr && A == IFA) ? D_IN : m_if;
      m_if = ((base & ~clr) | set) & 8'h1F;
      if (wr && A == IEA) m_ie = D_IN;
      m_sp = IRQ_SRC; m_ap = CPU_IRQ_ACK; m_wp = WR; m_arm = 1'b1;
    end
  endtask

  function automatic logic [17:0] m_out();
    logic [7:0] trig, dout;
    logic       doe;
    trig = m_if & m_ie;
    doe  = RESET_N && RD && (A == IFA || A == IEA);
    dout = !doe ? 8'h00 : (A == IFA) ? (m_if | 8'hE0) : m_ie;
    return {trig, |trig, doe, dout};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [7:0] din, input logic [7:0] src, input logic [7:0] ack);
    @(negedge CLK);
    RD = rd; WR = wr; A = a; D_IN = din; IRQ_SRC = src; CPU_IRQ_ACK = ack;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    m_step();
  endtask

  typedef struct {
    logic        rd, wr;
    logic [15:0] a;
    logic [7:0]  din, src, ack, trig;
    logic        doe;
    logic [7:0]  dout;
  } vec_t;

  function automatic vec_t v(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [7:0] din, input logic [7:0] src, input logic [7:0] ack,
                             input logic [7:0] trig, input logic doe, input logic [7:0] dout);
    vec_t r;
    r.rd = rd; r.wr = wr; r.a = a; r.din = din; r.src = src; r.ack = ack;
    r.trig = trig; r.doe = doe; r.dout = dout;
    return r;
  endfunction

  vec_t tbl[25];

  initial begin
    //          rd    wr    a    din    src    ack   | trig  doe   dout
    tbl[0]  = v(1'b0, 1'b1, IEA, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    tbl[1]  = v(1'b0, 1'b0, IEA, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00);
    tbl[2]  = v(1'b1, 1'b0, IFA, 8'h00, 8'h01, 8'h00, 8'h01, 1'b1, 8'hE1);
    tbl[3]  = v(1'b1, 1'b0, IFA, 8'h00, 8'h01, 8'h00, 8'h01, 1'b1, 8'hE1);
    tbl[4]  = v(1'b1, 1'b0, IEA, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 8'h01);
    tbl[5]  = v(1'b0, 1'b1, IEA, 8'h1F, 8'h00, 8'h00, 8'h01, 1'b0, 8'h00);
    tbl[6]  = v(1'b0, 1'b0, IEA, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 8'h00);
    tbl[7]  = v(1'b0, 1'b1, IFA, 8'h05, 8'h00, 8'h00, 8'h01, 1'b0, 8'h00);
    tbl[8]  = v(1'b1, 1'b0, IFA, 8'h00, 8'h00, 8'h04, 8'h05, 1'b1, 8'hE5);
    tbl[9]  = v(1'b1, 1'b0, IFA, 8'h00, 8'h00, 8'h04, 8'h01, 1'b1, 8'hE1);
    tbl[10] = v(1'b0, 1'b0, IFA, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 8'h00);
    tbl[11] = v(1'b1, 1'b1, IFA, 8'h00, 8'h04, 8'h04, 8'h01, 1'b1, 8'hE1);
    tbl[12] = v(1'b1, 1'b0, IFA, 8'h00, 8'h00, 8'h00, 8'h04, 1'b1, 8'hE4);
    tbl[13] = v(1'b0, 1'b1, IFA, 8'h04, 8'h00, 8'h04, 8'h04, 1'b0, 8'h00);
    tbl[14] = v(1'b1, 1'b0, IFA, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hE0);
    tbl[15] = v(1'b0, 1'b1, IEA, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    tbl[16] = v(1'b0, 1'b0, IEA, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    tbl[17] = v(1'b0, 1'b1, IFA, 8'h1F, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    tbl[18] = v(1'b1, 1'b0, IFA, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hFF);
    tbl[19] = v(1'b0, 1'b1, IEA, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    tbl[20] = v(1'b1, 1'b0, IEA, 8'h00, 8'h00, 8'h00, 8'h1F, 1'b1, 8'hFF);
    tbl[21] = v(1'b0, 1'b1, IFA, 8'hFF, 8'h00, 8'h00, 8'h1F, 1'b0, 8'h00);
    tbl[22] = v(1'b1, 1'b0, IFA, 8'h00, 8'h00, 8'h00, 8'h1F, 1'b1, 8'hFF);
    tbl[23] = v(1'b1, 1'b1, OTH, 8'h00, 8'h00, 8'h00, 8'h1F, 1'b0, 8'h00);
    tbl[24] = v(1'b1, 1'b0, IFA, 8'h00, 8'h00, 8'h00, 8'h1F, 1'b1, 8'hFF);

    // Reset held with all sources high and a read pending.
    RESET_N = 1'b0; RD = 1'b1; WR = 1'b0; A = IFA; D_IN = 8'h00;
    IRQ_SRC = 8'h1F; CPU_IRQ_ACK = 8'h00;
    m_clear();
    #12;
    chk("rst_trig", CPU_IRQ_TRIG, 8'h00);
    chk("rst_wake", WAKE, 1'b0);
    chk("rst_doe",  D_OE, 1'b0);
    chk("rst_dout", D_OUT, 8'h00);
    @(negedge CLK); RESET_N = 1'b1; #1;
    chk("rel_read", {D_OE, D_OUT}, {1'b1, 8'hE0});
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, IFA, 8'h00, (i < 2) ? 8'h1F : 8'h00, 8'h00);
      chk("rel_held_src", {D_OE, D_OUT, CPU_IRQ_TRIG}, {1'b1, 8'hE0, 8'h00});
      tick();
    end
    set_in(1'b0, 1'b0, IFA, 8'h00, 8'h00, 8'h00);
    tick();

    foreach (tbl[i]) begin
      set_in(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].din, tbl[i].src, tbl[i].ack);
      chk($sformatf("vec%0d_trig", i), CPU_IRQ_TRIG, tbl[i].trig);
      chk($sformatf("vec%0d_wake", i), WAKE, |tbl[i].trig);
      chk($sformatf("vec%0d_read", i), {D_OE, D_OUT}, {tbl[i].doe, tbl[i].dout});
      tick();
    end

    // WR held four cycles while source 1 rises: only the first cycle commits.
    set_in(1'b0, 1'b1, IFA, 8'h00, 8'h00, 8'h00); tick();
    set_in(1'b0, 1'b1, IFA, 8'h00, 8'h02, 8'h00);
    chk("hold_wr_c1", CPU_IRQ_TRIG, 8'h00); tick();
    set_in(1'b0, 1'b1, IFA, 8'h00, 8'h02, 8'h00);
    chk("hold_wr_c2", CPU_IRQ_TRIG, 8'h02); tick();
    set_in(1'b0, 1'b1, IFA, 8'h00, 8'h02, 8'h00);
    chk("hold_wr_c3", CPU_IRQ_TRIG, 8'h02); tick();
    set_in(1'b1, 1'b0, IFA, 8'h00, 8'h00, 8'h00);
    chk("hold_wr_if", {D_OUT, CPU_IRQ_TRIG}, {8'hE2, 8'h02}); tick();

    // Async reset between edges with everything pending.
    set_in(1'b0, 1'b1, IFA, 8'hFF, 8'h00, 8'h00); tick();
    set_in(1'b1, 1'b0, IFA, 8'h00, 8'h00, 8'h00);
    chk("pre_rst_trig", CPU_IRQ_TRIG, 8'h1F);
    #2 RESET_N = 1'b0; m_clear(); #1;
    chk("async_rst_trig", CPU_IRQ_TRIG, 8'h00);
    chk("async_rst_wake", WAKE, 1'b0);
    chk("async_rst_doe",  D_OE, 1'b0);
    IRQ_SRC = 8'h1F;
    tick();
    @(negedge CLK); RESET_N = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, IFA, 8'h00, 8'h1F, 8'h00);
      chk("rel2_held_src", {D_OUT, CPU_IRQ_TRIG, WAKE}, {8'hE0, 8'h00, 1'b0});
      tick();
    end

    // Randomized run against the reference model.
    for (int c = 0; c < 800; c++) begin
      logic [15:0] a;
      logic [7:0]  src;
      @(negedge CLK);
      case ($urandom_range(0, 3))
        0, 1:    a = IFA;
        2:       a = IEA;
        default: a = 16'($urandom);
      endcase
      src = IRQ_SRC;
      if ($urandom_range(0, 3) == 0) src = 8'($urandom);
      RESET_N     = ($urandom_range(0, 49) != 0);
      RD          = 1'($urandom);
      WR          = ($urandom_range(0, 2) == 0);
      A           = a;
      D_IN        = 8'($urandom);
      IRQ_SRC     = src;
      CPU_IRQ_ACK = ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      #1;
      if (!RESET_N) m_clear();
      chk("rand", {CPU_IRQ_TRIG, WAKE, D_OE, D_OUT}, m_out());
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
